// File: rtl/conv_window_gen_pkg.sv
// Shared constants, FSM state type and rotating-slot helper for the 3x3 window generator.
package cnn_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned COLS  = 416;
    localparam int unsigned ROWS  = 418;
    localparam int unsigned IDX_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        EMIT,
        WAIT_ROW,
        DONE
    } state_t;

    // (ptr + k) mod 3 for ptr, k in 0..2.
    function automatic logic [1:0] slot_idx(input logic [1:0] ptr, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, ptr} + {1'b0, k};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Row input and window output handshakes of the window generator.
interface conv_window_gen_if #(
    parameter int unsigned PIX_W = cnn_pkg::PIX_W,
    parameter int unsigned COLS  = cnn_pkg::COLS
);
    localparam int unsigned ROW_W = (COLS + 2) * PIX_W;
    localparam int unsigned WIN_W = 9 * PIX_W;

    logic                         row_valid;
    logic                         row_ready;
    logic [ROW_W-1:0]             R_padded;
    logic [ROW_W-1:0]             G_padded;
    logic [ROW_W-1:0]             B_padded;
    logic                         win_valid;
    logic                         win_ready;
    logic [WIN_W-1:0]             win_R;
    logic [WIN_W-1:0]             win_G;
    logic [WIN_W-1:0]             win_B;
    logic [cnn_pkg::IDX_W-1:0]    win_row;
    logic [cnn_pkg::IDX_W-1:0]    win_col;

    modport slave (
        input  row_valid, R_padded, G_padded, B_padded, win_ready,
        output row_ready, win_valid, win_R, win_G, win_B, win_row, win_col
    );

    modport master (
        output row_valid, R_padded, G_padded, B_padded, win_ready,
        input  row_ready, win_valid, win_R, win_G, win_B, win_row, win_col
    );

endinterface

// File: rtl/conv_window_gen_tap3_select.sv
// Picks pixels col, col+1, col+2 out of one zero-padded row (combinational).
module tap3_select #(
    parameter int unsigned PIX_W = cnn_pkg::PIX_W,
    parameter int unsigned COLS  = cnn_pkg::COLS
) (
    input  logic [(COLS+2)*PIX_W-1:0] row,
    input  logic [cnn_pkg::IDX_W-1:0] col,
    output logic [3*PIX_W-1:0]        taps
);

    always_comb begin
        taps = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col == cnn_pkg::IDX_W'(c)) begin
                taps = row[c*PIX_W +: 3*PIX_W];
            end
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Rotating 3-row buffer that emits 3x3 RGB windows, one output column per handshake.
module conv_window_gen #(
    parameter int unsigned PIX_W = cnn_pkg::PIX_W,
    parameter int unsigned COLS  = cnn_pkg::COLS,
    parameter int unsigned ROWS  = cnn_pkg::ROWS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    conv_window_gen_if.slave bus,
    output logic             busy,
    output logic             frame_done
);
    import cnn_pkg::*;

    localparam int unsigned ROW_W = (COLS + 2) * PIX_W;
    localparam int unsigned WIN_W = 9 * PIX_W;
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 3);

    state_t           state_q, state_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rows_loaded_q, rows_loaded_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] out_row_q, out_row_d;
    logic             row_we;
    logic             row_ready;
    logic             win_valid;

    logic [ROW_W-1:0] slot_r_q [3];
    logic [ROW_W-1:0] slot_g_q [3];
    logic [ROW_W-1:0] slot_b_q [3];
    logic [ROW_W-1:0] slot_r_d [3];
    logic [ROW_W-1:0] slot_g_d [3];
    logic [ROW_W-1:0] slot_b_d [3];

    logic [ROW_W-1:0] sel_r [3];
    logic [ROW_W-1:0] sel_g [3];
    logic [ROW_W-1:0] sel_b [3];
    logic [WIN_W-1:0] win_r, win_g, win_b;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rows_loaded_d = rows_loaded_q;
        col_d         = col_q;
        out_row_d     = out_row_q;
        row_we        = 1'b0;
        row_ready     = 1'b0;
        win_valid     = 1'b0;
        frame_done    = 1'b0;
        busy          = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = FILL;
                    rows_loaded_d = '0;
                    out_row_d     = '0;
                    col_d         = '0;
                end
            end
            FILL: begin
                row_ready = 1'b1;
                if (bus.row_valid) begin
                    row_we        = 1'b1;
                    wr_ptr_d      = slot_idx(wr_ptr_q, 2'd1);
                    rows_loaded_d = (rows_loaded_q == 2'd3) ? 2'd3 : rows_loaded_q + 2'd1;
                    if (rows_loaded_q == 2'd2) begin
                        state_d = EMIT;
                        col_d   = '0;
                    end
                end
            end
            EMIT: begin
                win_valid = 1'b1;
                if (bus.win_ready) begin
                    if (col_q != COL_LAST) begin
                        col_d = col_q + IDX_W'(1);
                    end else if (out_row_q == ROW_LAST) begin
                        state_d = DONE;
                    end else begin
                        col_d     = '0;
                        out_row_d = out_row_q + IDX_W'(1);
                        state_d   = WAIT_ROW;
                    end
                end
            end
            WAIT_ROW: begin
                row_ready = 1'b1;
                if (bus.row_valid) begin
                    row_we        = 1'b1;
                    wr_ptr_d      = slot_idx(wr_ptr_q, 2'd1);
                    rows_loaded_d = (rows_loaded_q == 2'd3) ? 2'd3 : rows_loaded_q + 2'd1;
                    col_d         = '0;
                    state_d       = EMIT;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The incoming row always lands in the oldest slot, which wr_ptr names.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            slot_r_d[i] = slot_r_q[i];
            slot_g_d[i] = slot_g_q[i];
            slot_b_d[i] = slot_b_q[i];
            if (row_we && (wr_ptr_q == 2'(i))) begin
                slot_r_d[i] = bus.R_padded;
                slot_g_d[i] = bus.G_padded;
                slot_b_d[i] = bus.B_padded;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rows_loaded_q <= '0;
            col_q         <= '0;
            out_row_q     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                slot_r_q[i] <= '0;
                slot_g_q[i] <= '0;
                slot_b_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rows_loaded_q <= rows_loaded_d;
            col_q         <= col_d;
            out_row_q     <= out_row_d;
            for (int unsigned i = 0; i < 3; i++) begin
                slot_r_q[i] <= slot_r_d[i];
                slot_g_q[i] <= slot_g_d[i];
                slot_b_q[i] <= slot_b_d[i];
            end
        end
    end

    // Window row r (0 = top/oldest) comes from slot (wr_ptr + r) mod 3.
    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            case (slot_idx(wr_ptr_q, 2'(r)))
                2'd0: begin
                    sel_r[r] = slot_r_q[0];
                    sel_g[r] = slot_g_q[0];
                    sel_b[r] = slot_b_q[0];
                end
                2'd1: begin
                    sel_r[r] = slot_r_q[1];
                    sel_g[r] = slot_g_q[1];
                    sel_b[r] = slot_b_q[1];
                end
                default: begin
                    sel_r[r] = slot_r_q[2];
                    sel_g[r] = slot_g_q[2];
                    sel_b[r] = slot_b_q[2];
                end
            endcase
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        tap3_select #(.PIX_W(PIX_W), .COLS(COLS)) u_tap_r (
            .row  (sel_r[r]),
            .col  (col_q),
            .taps (win_r[r*3*PIX_W +: 3*PIX_W])
        );
        tap3_select #(.PIX_W(PIX_W), .COLS(COLS)) u_tap_g (
            .row  (sel_g[r]),
            .col  (col_q),
            .taps (win_g[r*3*PIX_W +: 3*PIX_W])
        );
        tap3_select #(.PIX_W(PIX_W), .COLS(COLS)) u_tap_b (
            .row  (sel_b[r]),
            .col  (col_q),
            .taps (win_b[r*3*PIX_W +: 3*PIX_W])
        );
    end

    assign bus.row_ready = row_ready;
    assign bus.win_valid = win_valid;
    assign bus.win_R     = win_r;
    assign bus.win_G     = win_g;
    assign bus.win_B     = win_b;
    assign bus.win_row   = out_row_q;
    assign bus.win_col   = col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a reduced 16-column, 6-row frame.
module tb_conv_window_gen;

    localparam int unsigned PW    = 8;
    localparam int unsigned NC    = 16;
    localparam int unsigned NR    = 6;
    localparam int unsigned ROW_W = (NC + 2) * PW;
    localparam int unsigned WIN_W = 9 * PW;
    localparam int unsigned NWIN  = (NR - 2) * NC;

    typedef struct {
        logic [8:0]       row;
        logic [8:0]       col;
        logic [WIN_W-1:0] r;
        logic [WIN_W-1:0] g;
        logic [WIN_W-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic frame_done;

    conv_window_gen_if #(.PIX_W(PW), .COLS(NC)) bus ();

    conv_window_gen #(.PIX_W(PW), .COLS(NC), .ROWS(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.slave),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned nwin  = 0;
    int unsigned loaded = 0;
    exp_t sb[$];
    logic [ROW_W-1:0] hr [3];
    logic [ROW_W-1:0] hg [3];
    logic [ROW_W-1:0] hb [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] mk_row(input int unsigned kind, input int unsigned ch);
        logic [ROW_W-1:0] v;
        logic [7:0] px;
        v = '0;
        for (int unsigned p = 0; p < NC + 2; p++) begin
            case (kind)
                0: px = 8'h00;
                1: px = 8'(p);
                2: px = 8'hFF;
                3: px = 8'h55;
                4: px = 8'(p * 7 + ch * 31);
                5: px = 8'(p) ^ 8'hA5 ^ 8'(ch);
                6: px = 8'h10 + 8'(ch);
                7: px = 8'h20 + 8'(ch);
                8: px = 8'h30 + 8'(ch);
                default: px = 8'h00;
            endcase
            v[p*PW +: PW] = px;
        end
        return v;
    endfunction

    function automatic logic [WIN_W-1:0] win_of(input logic [ROW_W-1:0] t, input logic [ROW_W-1:0] m,
                                                 input logic [ROW_W-1:0] b, input int unsigned c);
        logic [WIN_W-1:0] w;
        for (int unsigned k = 0; k < 3; k++) begin
            w[k*PW +: PW]       = t[(c+k)*PW +: PW];
            w[(3+k)*PW +: PW]   = m[(c+k)*PW +: PW];
            w[(6+k)*PW +: PW]   = b[(c+k)*PW +: PW];
        end
        return w;
    endfunction

    // Offer one row, wait for acceptance, then update the reference history.
    task automatic send_row(input int unsigned kind);
        logic ok;
        exp_t e;
        ok = 1'b0;
        bus.R_padded  = mk_row(kind, 0);
        bus.G_padded  = mk_row(kind, 1);
        bus.B_padded  = mk_row(kind, 2);
        bus.row_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.row_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.row_valid = 1'b0;
        chk("row_accept", {127'd0, ok}, 128'd1);
        if (ok) begin
            for (int unsigned i = 0; i < 2; i++) begin
                hr[i] = hr[i+1];
                hg[i] = hg[i+1];
                hb[i] = hb[i+1];
            end
            hr[2] = mk_row(kind, 0);
            hg[2] = mk_row(kind, 1);
            hb[2] = mk_row(kind, 2);
            loaded++;
            if (loaded >= 3) begin
                for (int unsigned c = 0; c < NC; c++) begin
                    e.row = 9'(loaded - 3);
                    e.col = 9'(c);
                    e.r   = win_of(hr[0], hr[1], hr[2], c);
                    e.g   = win_of(hg[0], hg[1], hg[2], c);
                    e.b   = win_of(hb[0], hb[1], hb[2], c);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        loaded = 0;
        nwin   = 0;
    endtask

    task automatic wait_done(output int unsigned fd);
        fd = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) fd++;
            if (!busy) break;
        end
        chk("done_reached_idle", {127'd0, busy}, 128'd0);
    endtask

    // Monitor: every accepted window is checked against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.win_valid && bus.win_ready) begin
                nwin++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_window row=%0d col=%0d", bus.win_row, bus.win_col);
                end else begin
                    e = sb.pop_front();
                    chk("win_row", {119'd0, bus.win_row}, {119'd0, e.row});
                    chk("win_col", {119'd0, bus.win_col}, {119'd0, e.col});
                    chk("win_R", {56'd0, bus.win_R}, {56'd0, e.r});
                    chk("win_G", {56'd0, bus.win_G}, {56'd0, e.g});
                    chk("win_B", {56'd0, bus.win_B}, {56'd0, e.b});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned fd;
        logic [WIN_W-1:0] hold;
        reset = 1'b0;
        start = 1'b0;
        bus.row_valid = 1'b0;
        bus.win_ready = 1'b0;
        bus.R_padded  = '0;
        bus.G_padded  = '0;
        bus.B_padded  = '0;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start         = 1'($urandom);
            bus.row_valid = 1'($urandom);
            bus.win_ready = 1'($urandom);
            bus.R_padded  = ROW_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
            bus.G_padded  = ROW_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
            bus.B_padded  = ROW_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
            chk("rst_row_ready", {127'd0, bus.row_ready}, 128'd0);
            chk("rst_win_valid", {127'd0, bus.win_valid}, 128'd0);
            chk("rst_busy", {127'd0, busy}, 128'd0);
            chk("rst_frame_done", {127'd0, frame_done}, 128'd0);
            chk("rst_win_R", {56'd0, bus.win_R}, 128'd0);
            chk("rst_win_idx", {110'd0, bus.win_row, bus.win_col}, 128'd0);
        end
        start = 1'b0;
        bus.row_valid = 1'b0;
        bus.win_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Frame A: directed fill, back-pressure, rotation, full frame.
        pulse_start();
        chk("start_row_ready", {127'd0, bus.row_ready}, 128'd1);
        chk("start_busy", {127'd0, busy}, 128'd1);
        send_row(0);
        send_row(1);
        send_row(2);
        chk("first_valid", {127'd0, bus.win_valid}, 128'd1);
        chk("first_idx", {110'd0, bus.win_row, bus.win_col}, 128'd0);
        chk("first_win_R", {56'd0, bus.win_R}, {56'd0, 72'hFFFFFF_020100_000000});
        chk("first_win_G", {56'd0, bus.win_G}, {56'd0, 72'hFFFFFF_020100_000000});

        bus.win_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.win_col == 9'd10) break;
        end
        bus.win_ready = 1'b0;
        hold = bus.win_R;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_col", {119'd0, bus.win_col}, 128'd10);
            chk("bp_valid", {127'd0, bus.win_valid}, 128'd1);
            chk("bp_win_R", {56'd0, bus.win_R}, {56'd0, hold});
        end
        bus.win_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_col", {119'd0, bus.win_col}, 128'd11);

        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!bus.win_valid) break;
        end
        chk("rot_valid", {127'd0, bus.win_valid}, 128'd0);
        chk("rot_row_ready", {127'd0, bus.row_ready}, 128'd1);
        chk("rot_win_row", {119'd0, bus.win_row}, 128'd1);
        send_row(3);
        chk("rot_win_R", {56'd0, bus.win_R}, {56'd0, 72'h555555_FFFFFF_020100});
        chk("rot_idx", {110'd0, bus.win_row, bus.win_col}, {110'd0, 9'd1, 9'd0});
        send_row(4);
        send_row(5);
        wait_done(fd);
        chk("a_frame_done_pulses", 128'(fd), 128'd1);
        chk("a_window_count", 128'(nwin), 128'(NWIN));
        chk("a_sb_empty", 128'(sb.size()), 128'd0);
        chk("a_idle_row_ready", {127'd0, bus.row_ready}, 128'd0);

        // Frame B: aborted by reset in the middle of a row.
        pulse_start();
        send_row(5);
        send_row(4);
        send_row(1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.win_valid && bus.win_col == 9'd8) break;
        end
        reset = 1'b0;
        #1;
        chk("abort_win_valid", {127'd0, bus.win_valid}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_row_ready", {127'd0, bus.row_ready}, 128'd0);
        chk("abort_win_R", {56'd0, bus.win_R}, 128'd0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {127'd0, frame_done}, 128'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Frame C: fresh data after the abort.
        pulse_start();
        send_row(6);
        send_row(7);
        send_row(8);
        chk("c_first_idx", {110'd0, bus.win_row, bus.win_col}, 128'd0);
        chk("c_first_win_R", {56'd0, bus.win_R}, {56'd0, 72'h303030_202020_101010});
        chk("c_first_win_B", {56'd0, bus.win_B}, {56'd0, 72'h323232_222222_121212});
        send_row(4);
        send_row(5);
        send_row(1);
        wait_done(fd);
        chk("c_frame_done_pulses", 128'(fd), 128'd1);
        chk("c_window_count", 128'(nwin), 128'(NWIN));
        chk("c_sb_empty", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
